// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the decode-to-execute payload record.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ALU_ADD  = 3'b000;
    localparam logic [2:0] F3_ALU_SLL  = 3'b001;
    localparam logic [2:0] F3_ALU_SLT  = 3'b010;
    localparam logic [2:0] F3_ALU_SLTU = 3'b011;
    localparam logic [2:0] F3_ALU_XOR  = 3'b100;
    localparam logic [2:0] F3_ALU_SR   = 3'b101;
    localparam logic [2:0] F3_ALU_OR   = 3'b110;
    localparam logic [2:0] F3_ALU_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [2:0]      alu_op;
        logic            alt_op;
        logic [XLEN-1:0] operand1;
        logic [XLEN-1:0] operand2;
        logic [4:0]      rd;
        logic            rd_we;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } id_ex_t;

    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == F3_ALU_SLL) || (f3 == F3_ALU_SR);
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// Integer register file: two async read ports, one sync write port, x0 hard-wired to zero.
// Optional same-cycle write-to-read forwarding when RF_BYPASS_EN is defined.
module regfile
    import riscv_pkg::*;
#(
    parameter int REG_COUNT = 32
) (
    input  logic            clk_i,
    input  logic [4:0]      rs1_idx,
    output logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      rs2_idx,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [4:0]      wr_idx,
    input  logic [XLEN-1:0] wr_data
);

    localparam int AW = $clog2(REG_COUNT);

    logic [XLEN-1:0] mem [REG_COUNT];
    logic            wr_ok;

    assign wr_ok = wr_en && (wr_idx != 5'd0) && (int'(wr_idx) < REG_COUNT);

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem[wr_idx[AW-1:0]] <= wr_data;
        end
    end

    // Out-of-range indices read as zero; decode flags them illegal anyway.
    always_comb begin
        rs1_data = '0;
        if ((rs1_idx != 5'd0) && (int'(rs1_idx) < REG_COUNT)) begin
            rs1_data = mem[rs1_idx[AW-1:0]];
`ifdef RF_BYPASS_EN
            if (wr_ok && (wr_idx == rs1_idx)) begin
                rs1_data = wr_data;
            end
`endif
        end
    end

    always_comb begin
        rs2_data = '0;
        if ((rs2_idx != 5'd0) && (int'(rs2_idx) < REG_COUNT)) begin
            rs2_data = mem[rs2_idx[AW-1:0]];
`ifdef RF_BYPASS_EN
            if (wr_ok && (wr_idx == rs2_idx)) begin
                rs2_data = wr_data;
            end
`endif
        end
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage for OP, OP-IMM, LUI and AUIPC feeding a one-entry registered execute slot.
// Build option: RF_BYPASS_EN forwards a same-cycle writeback to the register reads.
module id_stage
    import riscv_pkg::*;
#(
    parameter int REG_COUNT = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        if_valid_i,
    output logic        if_ready_o,
    input  logic [31:0] if_instr_i,
    input  logic [31:0] if_pc_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [2:0]  ex_alu_op_o,
    output logic        ex_alt_op_o,
    output logic [31:0] ex_operand1_o,
    output logic [31:0] ex_operand2_o,
    output logic [4:0]  ex_rd_o,
    output logic        ex_rd_we_o,
    output logic [31:0] ex_pc_o,
    output logic        ex_illegal_o
);

    function automatic logic [XLEN-1:0] sext_imm_i(input logic [31:0] instr);
        logic signed [11:0]     imm;
        logic signed [XLEN-1:0] ext;
        imm = instr[31:20];
        ext = imm;
        return ext;
    endfunction

    function automatic logic [XLEN-1:0] shamt(input logic [4:0] amount);
        return {{(XLEN-5){1'b0}}, amount};
    endfunction

    function automatic logic idx_ok(input logic [4:0] idx);
        return int'(idx) < REG_COUNT;
    endfunction

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = if_instr_i[6:0];
    assign rd     = if_instr_i[11:7];
    assign f3     = if_instr_i[14:12];
    assign rs1    = if_instr_i[19:15];
    assign rs2    = if_instr_i[24:20];
    assign f7     = if_instr_i[31:25];

    logic [XLEN-1:0] rs1_data, rs2_data;

    regfile #(
        .REG_COUNT(REG_COUNT)
    ) u_regfile (
        .clk_i    (clk_i),
        .rs1_idx  (rs1),
        .rs1_data (rs1_data),
        .rs2_idx  (rs2),
        .rs2_data (rs2_data),
        .wr_en    (wb_we_i),
        .wr_idx   (wb_rd_i),
        .wr_data  (wb_data_i)
    );

    // Stage p0: combinational decode of the offered instruction
    id_ex_t dec_p0;
    logic   legal_p0;
    logic   fmt_ok;

    always_comb begin
        dec_p0    = '0;
        dec_p0.pc = if_pc_i;
        dec_p0.rd = rd;
        legal_p0  = 1'b0;
        fmt_ok    = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                dec_p0.alu_op   = f3;
                dec_p0.operand1 = rs1_data;
                dec_p0.operand2 = is_shift(f3) ? shamt(rs2_data[4:0]) : rs2_data;
                dec_p0.alt_op   = ((f3 == F3_ALU_ADD) || (f3 == F3_ALU_SR)) ? f7[5] : 1'b0;
                fmt_ok = (f7 == F7_BASE) ||
                         ((f7 == F7_ALT) && ((f3 == F3_ALU_ADD) || (f3 == F3_ALU_SR)));
                legal_p0 = fmt_ok && idx_ok(rs1) && idx_ok(rs2) && idx_ok(rd);
            end
            OPC_OP_IMM: begin
                dec_p0.alu_op   = f3;
                dec_p0.operand1 = rs1_data;
                dec_p0.operand2 = sext_imm_i(if_instr_i);
                fmt_ok          = 1'b1;
                if (f3 == F3_ALU_SLL) begin
                    dec_p0.operand2 = shamt(rs2);
                    fmt_ok          = (f7 == F7_BASE);
                end else if (f3 == F3_ALU_SR) begin
                    // Only imm[4:0] is a shift amount; bit 10 selects SRAI.
                    dec_p0.operand2 = shamt(rs2);
                    dec_p0.alt_op   = if_instr_i[30];
                    fmt_ok          = (f7 == F7_BASE) || (f7 == F7_ALT);
                end
                legal_p0 = fmt_ok && idx_ok(rs1) && idx_ok(rd);
            end
            OPC_LUI: begin
                dec_p0.alu_op   = F3_ALU_ADD;
                dec_p0.operand2 = {if_instr_i[31:12], 12'b0};
                legal_p0        = idx_ok(rd);
            end
            OPC_AUIPC: begin
                dec_p0.alu_op   = F3_ALU_ADD;
                dec_p0.operand1 = if_pc_i;
                dec_p0.operand2 = {if_instr_i[31:12], 12'b0};
                legal_p0        = idx_ok(rd);
            end
            default: begin
                legal_p0 = 1'b0;
            end
        endcase
        dec_p0.illegal = ~legal_p0;
        dec_p0.rd_we   = legal_p0 && (rd != 5'd0);
    end

    // Stage p1: registered execute slot
    id_ex_t slot_p1;
    logic   vld_p1;
    logic   transfer;

    assign if_ready_o = flush_i | ~vld_p1 | ex_ready_i;
    assign transfer   = if_valid_i & if_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1  <= 1'b0;
            slot_p1 <= '0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
        end else if (transfer) begin
            vld_p1  <= 1'b1;
            slot_p1 <= dec_p0;
        end else if (ex_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    assign ex_valid_o    = vld_p1;
    assign ex_alu_op_o   = slot_p1.alu_op;
    assign ex_alt_op_o   = slot_p1.alt_op;
    assign ex_operand1_o = slot_p1.operand1;
    assign ex_operand2_o = slot_p1.operand2;
    assign ex_rd_o       = slot_p1.rd;
    assign ex_rd_we_o    = slot_p1.rd_we;
    assign ex_pc_o       = slot_p1.pc;
    assign ex_illegal_o  = slot_p1.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: decode vector table plus stall, flush, reset and writeback-forwarding sequences.
module tb_id_stage;

    typedef struct {
        logic [2:0]  op;
        logic        alt;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] pc;
        logic        ill;
        logic        chk_ops;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready_o;
    logic [31:0] if_instr = '0;
    logic [31:0] if_pc = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        ex_valid_o;
    logic        ex_ready = 1'b1;
    logic [2:0]  ex_alu_op_o;
    logic        ex_alt_op_o;
    logic [31:0] ex_operand1_o, ex_operand2_o, ex_pc_o;
    logic [4:0]  ex_rd_o;
    logic        ex_rd_we_o, ex_illegal_o;

    id_stage #(
        .REG_COUNT(32)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .if_valid_i    (if_valid),
        .if_ready_o    (if_ready_o),
        .if_instr_i    (if_instr),
        .if_pc_i       (if_pc),
        .wb_we_i       (wb_we),
        .wb_rd_i       (wb_rd),
        .wb_data_i     (wb_data),
        .ex_valid_o    (ex_valid_o),
        .ex_ready_i    (ex_ready),
        .ex_alu_op_o   (ex_alu_op_o),
        .ex_alt_op_o   (ex_alt_op_o),
        .ex_operand1_o (ex_operand1_o),
        .ex_operand2_o (ex_operand2_o),
        .ex_rd_o       (ex_rd_o),
        .ex_rd_we_o    (ex_rd_we_o),
        .ex_pc_o       (ex_pc_o),
        .ex_illegal_o  (ex_illegal_o)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t pending;
    logic acc;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [2:0] op, input logic alt,
                                input logic [31:0] op1, input logic [31:0] op2, input logic [4:0] rd,
                                input logic we, input logic [31:0] pc, input logic ill);
        vec_t v;
        v.instr     = instr;
        v.e.op      = op;
        v.e.alt     = alt;
        v.e.op1     = op1;
        v.e.op2     = op2;
        v.e.rd      = rd;
        v.e.we      = we;
        v.e.pc      = pc;
        v.e.ill     = ill;
        v.e.chk_ops = ~ill;
        return v;
    endfunction

    task automatic check_slot();
        exp_t e;
        chk("ex_valid", {31'b0, ex_valid_o}, {31'b0, sb.size() != 0});
        if (sb.size() != 0) begin
            e = sb[0];
            chk("ex_illegal", {31'b0, ex_illegal_o}, {31'b0, e.ill});
            chk("ex_rd_we", {31'b0, ex_rd_we_o}, {31'b0, e.we});
            chk("ex_rd", {27'b0, ex_rd_o}, {27'b0, e.rd});
            chk("ex_pc", ex_pc_o, e.pc);
            if (e.chk_ops) begin
                chk("ex_alu_op", {29'b0, ex_alu_op_o}, {29'b0, e.op});
                chk("ex_alt_op", {31'b0, ex_alt_op_o}, {31'b0, e.alt});
                chk("ex_operand1", ex_operand1_o, e.op1);
                chk("ex_operand2", ex_operand2_o, e.op2);
            end
        end
    endtask

    // One clock: compare held slot, check ready, advance the scoreboard, step past the edge.
    task automatic tick();
        logic exp_rdy;
        @(negedge clk);
        check_slot();
        exp_rdy = flush | (sb.size() == 0) | ex_ready;
        chk("if_ready", {31'b0, if_ready_o}, {31'b0, exp_rdy});
        acc = if_valid & exp_rdy;
        if (rst) begin
            sb.delete();
        end else begin
            if ((sb.size() != 0) && (flush || ex_ready)) void'(sb.pop_front());
            if (acc && !flush) sb.push_back(pending);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input vec_t v, output int n);
        if_valid = 1'b1;
        if_instr = v.instr;
        if_pc    = v.e.pc;
        pending  = v.e;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 20) begin
            tick();
            n++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        if_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        wb_we   = 1'b1;
        wb_rd   = rd;
        wb_data = data;
        tick();
        wb_we = 1'b0;
    endtask

    initial begin
        int   n;
        vec_t va, vb;
        logic [31:0] byp_exp;

        vecs.push_back(mk(32'h402081B3, 3'd0, 1'b1, 32'd5,        32'd3,        5'd3,  1'b1, 32'h1000, 1'b0));
        vecs.push_back(mk(32'h4030D213, 3'd5, 1'b1, 32'd5,        32'd3,        5'd4,  1'b1, 32'h1004, 1'b0));
        vecs.push_back(mk(32'hFFF00293, 3'd0, 1'b0, 32'd0,        32'hFFFFFFFF, 5'd5,  1'b1, 32'h1008, 1'b0));
        vecs.push_back(mk(32'h12345317, 3'd0, 1'b0, 32'h100,      32'h12345000, 5'd6,  1'b1, 32'h0100, 1'b0));
        vecs.push_back(mk(32'hABCDE037, 3'd0, 1'b0, 32'd0,        32'hABCDE000, 5'd0,  1'b0, 32'h1010, 1'b0));
        vecs.push_back(mk(32'h0000A483, 3'd0, 1'b0, 32'd0,        32'd0,        5'd9,  1'b0, 32'h1014, 1'b1));
        vecs.push_back(mk(32'h4083D533, 3'd5, 1'b1, 32'h80000001, 32'd3,        5'd10, 1'b1, 32'h1018, 1'b0));
        vecs.push_back(mk(32'h40008593, 3'd0, 1'b0, 32'd5,        32'h400,      5'd11, 1'b1, 32'h101C, 1'b0));
        vecs.push_back(mk(32'h4020E633, 3'd6, 1'b0, 32'd0,        32'd0,        5'd12, 1'b0, 32'h1020, 1'b1));
        vecs.push_back(mk(32'h01F09693, 3'd1, 1'b0, 32'd5,        32'd31,       5'd13, 1'b1, 32'h1024, 1'b0));
        vecs.push_back(mk(32'h41F09693, 3'd1, 1'b0, 32'd0,        32'd0,        5'd13, 1'b0, 32'h1028, 1'b1));
        vecs.push_back(mk(32'hFFB12713, 3'd2, 1'b0, 32'd3,        32'hFFFFFFFB, 5'd14, 1'b1, 32'h102C, 1'b0));
        vecs.push_back(mk(32'h0020C7B3, 3'd4, 1'b0, 32'd5,        32'd3,        5'd15, 1'b1, 32'h1030, 1'b0));
        vecs.push_back(mk(32'h0010D813, 3'd5, 1'b0, 32'd5,        32'd1,        5'd16, 1'b1, 32'h1034, 1'b0));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", {31'b0, ex_valid_o}, 32'd0);
        chk("rst_operand1", ex_operand1_o, 32'd0);
        chk("rst_operand2", ex_operand2_o, 32'd0);
        chk("rst_pc", ex_pc_o, 32'd0);
        chk("rst_misc", {24'b0, ex_alu_op_o, ex_alt_op_o, ex_rd_we_o, ex_illegal_o, 2'b0},
            32'd0);
        chk("rst_rd", {27'b0, ex_rd_o}, 32'd0);

        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd3);
        wb_write(5'd7, 32'h80000001);
        wb_write(5'd8, 32'd35);
        wb_write(5'd0, 32'hDEADBEEF);

        // Back-to-back table: each offer must be taken on its first cycle.
        ex_ready = 1'b1;
        foreach (vecs[i]) begin
            offer(vecs[i], n);
            chk("throughput", n, 32'd1);
        end
        repeat (2) tick();

        // Stall: slot full, execute not ready, next instruction waiting.
        ex_ready = 1'b0;
        offer(vecs[0], n);
        if_valid = 1'b1;
        if_instr = vecs[1].instr;
        if_pc    = vecs[1].e.pc;
        pending  = vecs[1].e;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_no_accept", {31'b0, acc}, 32'd0);
        end
        ex_ready = 1'b1;
        tick();
        chk("stall_release_accept", {31'b0, acc}, 32'd1);
        if_valid = 1'b0;
        offer(vecs[2], n);
        chk("post_stall_rate", n, 32'd1);
        offer(vecs[3], n);
        chk("post_stall_rate", n, 32'd1);
        repeat (2) tick();

        // Flush drops both the held slot and the instruction offered alongside it.
        ex_ready = 1'b0;
        offer(vecs[6], n);
        flush    = 1'b1;
        if_valid = 1'b1;
        if_instr = vecs[7].instr;
        if_pc    = vecs[7].e.pc;
        pending  = vecs[7].e;
        tick();
        chk("flush_consumes", {31'b0, acc}, 32'd1);
        flush    = 1'b0;
        if_valid = 1'b0;
        chk("flush_empty", {31'b0, ex_valid_o}, 32'd0);
        ex_ready = 1'b1;
        repeat (3) tick();

        // Reset outranks flush and a concurrent load.
        ex_ready = 1'b0;
        offer(vecs[9], n);
        rst      = 1'b1;
        flush    = 1'b1;
        if_valid = 1'b1;
        if_instr = vecs[12].instr;
        if_pc    = vecs[12].e.pc;
        pending  = vecs[12].e;
        tick();
        rst      = 1'b0;
        flush    = 1'b0;
        if_valid = 1'b0;
        chk("rst_flush_empty", {31'b0, ex_valid_o}, 32'd0);
        chk("rst_flush_op1", ex_operand1_o, 32'd0);
        ex_ready = 1'b1;
        tick();

        // Writeback to x1 in the same cycle it is read.
`ifdef RF_BYPASS_EN
        byp_exp = 32'h77;
`else
        byp_exp = 32'd5;
`endif
        va = mk(32'h000088B3, 3'd0, 1'b0, byp_exp, 32'd0, 5'd17, 1'b1, 32'h2000, 1'b0);
        wb_we   = 1'b1;
        wb_rd   = 5'd1;
        wb_data = 32'h77;
        offer(va, n);
        wb_we = 1'b0;
        vb = mk(32'h00008933, 3'd0, 1'b0, 32'h77, 32'd0, 5'd18, 1'b1, 32'h2004, 1'b0);
        offer(vb, n);
        vb = mk(32'h000009B3, 3'd0, 1'b0, 32'd0, 32'd0, 5'd19, 1'b1, 32'h2008, 1'b0);
        offer(vb, n);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
